trap_sequencer: RTL and testbench



---
 rtl/trap_pkg.sv | 26 ++
 rtl/trap_sequencer.sv | 140 ++++++++++++++
 tb/tb_trap_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap entry/exit sequencer.
package trap_pkg;

  // Sequencer states; StSaveTval is only reachable when TRAP_MTVAL_EN is defined.
  typedef enum logic [2:0] {
    StIdle,
    StSaveEpc,
    StSaveCause,
    StSaveTval,
    StReadTvec,
    StReadEpc,
    StRedirect
  } trap_state_e;

  // Machine-mode CSR addresses touched by the sequencer.
  localparam logic [11:0] MEPC   = 12'h341;
  localparam logic [11:0] MCAUSE = 12'h342;
  localparam logic [11:0] MTVAL  = 12'h343;
  localparam logic [11:0] MTVEC  = 12'h305;

  // Cause codes raised by the decode/memory logic.
  localparam logic [3:0] CAUSE_ROM_FAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL_OP = 4'd2;
  localparam logic [3:0] CAUSE_RAM_FAULT  = 4'd5;

endpackage

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: saves mepc/mcause/(mtval), fetches mtvec and
// redirects the PC; on mret reads mepc back and redirects to it.
// Optional macro TRAP_MTVAL_EN adds the SAVE_TVAL write and the tval register.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CSR_AW  = 12,
  parameter int unsigned CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exc_valid,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               mret,
  input  logic [XLEN-1:0]    rd,
  output logic               csr_w,
  output logic [CSR_AW-1:0]  csr,
  output logic [XLEN-1:0]    wd,
  output logic               stall,
  output logic               pc_redirect,
  output logic [XLEN-1:0]    pc_target,
  output logic               busy
);

  // Clears bits [1:0] so saved and fetched PCs are always word aligned.
  localparam logic [XLEN-1:0] AlignMask = {{(XLEN-2){1'b1}}, 2'b00};

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;

`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] tval_q, tval_d;
`else
  // exc_tval has no consumer when mtval saving is compiled out.
  logic unused_tval;
  assign unused_tval = ^exc_tval;
`endif

  // State and capture registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
`ifdef TRAP_MTVAL_EN
      tval_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
`ifdef TRAP_MTVAL_EN
      tval_q   <= tval_d;
`endif
    end
  end

  // Next-state, capture and Moore-decoded CSR/redirect outputs.
  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    target_d    = target_q;
`ifdef TRAP_MTVAL_EN
    tval_d      = tval_q;
`endif
    csr_w       = 1'b0;
    csr         = '0;
    wd          = '0;
    pc_redirect = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Exception has priority; a simultaneous mret is dropped.
        if (exc_valid) begin
          epc_d   = exc_pc;
          cause_d = XLEN'(exc_cause);
`ifdef TRAP_MTVAL_EN
          tval_d  = exc_tval;
`endif
          state_d = StSaveEpc;
        end else if (mret) begin
          state_d = StReadEpc;
        end
      end
      StSaveEpc: begin
        csr_w   = 1'b1;
        csr     = CSR_AW'(MEPC);
        wd      = epc_q & AlignMask;
        state_d = StSaveCause;
      end
      StSaveCause: begin
        csr_w   = 1'b1;
        csr     = CSR_AW'(MCAUSE);
        wd      = cause_q;
`ifdef TRAP_MTVAL_EN
        state_d = StSaveTval;
`else
        state_d = StReadTvec;
`endif
      end
`ifdef TRAP_MTVAL_EN
      StSaveTval: begin
        csr_w   = 1'b1;
        csr     = CSR_AW'(MTVAL);
        wd      = tval_q;
        state_d = StReadTvec;
      end
`endif
      StReadTvec: begin
        csr      = CSR_AW'(MTVEC);
        target_d = rd & AlignMask;
        state_d  = StRedirect;
      end
      StReadEpc: begin
        csr      = CSR_AW'(MEPC);
        target_d = rd & AlignMask;
        state_d  = StRedirect;
      end
      StRedirect: begin
        pc_redirect = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q != StIdle);
  // Stall is raised combinationally in the accepting cycle so the pipeline freezes at once.
  assign stall     = busy | exc_valid | mret;
  assign pc_target = target_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus random
// exception/mret traffic against a per-cycle expected-trace model.
module tb_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret;
  logic [31:0] rd;
  logic        csr_w;
  logic [11:0] csr;
  logic [31:0] wd;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        busy;

  trap_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exc_valid  (exc_valid),
    .exc_cause  (exc_cause),
    .exc_pc     (exc_pc),
    .exc_tval   (exc_tval),
    .mret       (mret),
    .rd         (rd),
    .csr_w      (csr_w),
    .csr        (csr),
    .wd         (wd),
    .stall      (stall),
    .pc_redirect(pc_redirect),
    .pc_target  (pc_target),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench CSR file: mtvec is set by the bench, the rest only by DUT writes.
  logic [31:0] m_mtvec;
  logic [31:0] m_mepc   = '0;
  logic [31:0] m_mcause = '0;
  logic [31:0] m_mtval  = '0;
  int          cnt_mepc = 0;
  int          cnt_mcause = 0;
  int          cnt_mtval = 0;

  always @(posedge clk) begin
    if (rst_n && csr_w) begin
      case (csr)
        12'h341: begin m_mepc   <= wd; cnt_mepc   <= cnt_mepc + 1;   end
        12'h342: begin m_mcause <= wd; cnt_mcause <= cnt_mcause + 1; end
        12'h343: begin m_mtval  <= wd; cnt_mtval  <= cnt_mtval + 1;  end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd = 32'h0;
    case (csr)
      12'h305: rd = m_mtvec;
      12'h341: rd = m_mepc;
      12'h342: rd = m_mcause;
      12'h343: rd = m_mtval;
      default: rd = 32'h0;
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One expected cycle of the trap sequence.
  typedef struct {
    bit          w;
    bit          chk_a;
    logic [11:0] a;
    logic [31:0] d;
    bit          redir;
  } step_t;

  logic [31:0] exp_mepc = '0;
  int          exp_mtval_cnt = 0;

  // Runs one exception (is_exc) or mret, optionally raising both together.
  task automatic run_seq(input bit is_exc, input logic [3:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input bit both, input string name);
    step_t       plan[$];
    step_t       s;
    logic [31:0] exp_tgt;
    plan = {};
    if (is_exc) begin
      plan.push_back('{w: 1, chk_a: 1, a: 12'h341, d: pc & 32'hFFFF_FFFC, redir: 0});
      plan.push_back('{w: 1, chk_a: 1, a: 12'h342, d: {28'h0, cause}, redir: 0});
`ifdef TRAP_MTVAL_EN
      plan.push_back('{w: 1, chk_a: 1, a: 12'h343, d: tval, redir: 0});
      exp_mtval_cnt++;
`endif
      plan.push_back('{w: 0, chk_a: 1, a: 12'h305, d: 0, redir: 0});
      exp_tgt = m_mtvec & 32'hFFFF_FFFC;
    end else begin
      plan.push_back('{w: 0, chk_a: 1, a: 12'h341, d: 0, redir: 0});
      exp_tgt = exp_mepc & 32'hFFFF_FFFC;
    end
    plan.push_back('{w: 0, chk_a: 0, a: 0, d: 0, redir: 1});

    @(negedge clk);
    exc_valid = is_exc;
    mret      = !is_exc || both;
    exc_cause = cause;
    exc_pc    = pc;
    exc_tval  = tval;
    #1;
    check_eq({name, "_stall_req"}, 32'(stall), 32'd1);
    check_eq({name, "_busy_pre"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    exc_valid = 1'b0;
    mret      = 1'b0;
    for (int k = 0; k < plan.size(); k++) begin
      s = plan[k];
      @(negedge clk);
      check_eq($sformatf("%s_c%0d_csr_w", name, k + 1), 32'(csr_w), 32'(s.w));
      if (s.chk_a) check_eq($sformatf("%s_c%0d_csr", name, k + 1), 32'(csr), 32'(s.a));
      if (s.w) check_eq($sformatf("%s_c%0d_wd", name, k + 1), wd, s.d);
      check_eq($sformatf("%s_c%0d_redir", name, k + 1), 32'(pc_redirect), 32'(s.redir));
      check_eq($sformatf("%s_c%0d_stall", name, k + 1), 32'(stall), 32'd1);
      if (s.redir) check_eq($sformatf("%s_c%0d_target", name, k + 1), pc_target, exp_tgt);
    end
    @(negedge clk);
    check_eq({name, "_stall_after"}, 32'(stall), 32'd0);
    check_eq({name, "_busy_after"}, 32'(busy), 32'd0);
    check_eq({name, "_redir_after"}, 32'(pc_redirect), 32'd0);
    check_eq({name, "_target_hold"}, pc_target, exp_tgt);
    if (is_exc) begin
      exp_mepc = pc & 32'hFFFF_FFFC;
      check_eq({name, "_mcause"}, m_mcause, {28'h0, cause});
`ifdef TRAP_MTVAL_EN
      check_eq({name, "_mtval"}, m_mtval, tval);
`endif
    end
  endtask

  int          snap_cause;
  int          snap_tval;
  logic [3:0]  r_cause;
  logic [31:0] r_pc;
  logic [31:0] r_tval;

  initial begin
    rst_n     = 1'b0;
    exc_valid = 1'b0;
    exc_cause = '0;
    exc_pc    = '0;
    exc_tval  = '0;
    mret      = 1'b0;
    m_mtvec   = 32'h100;
    #1;
    check_eq("rst_csr_w", 32'(csr_w), 32'd0);
    check_eq("rst_csr", 32'(csr), 32'd0);
    check_eq("rst_wd", wd, 32'd0);
    check_eq("rst_redir", 32'(pc_redirect), 32'd0);
    check_eq("rst_target", pc_target, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    mret = 1'b1;
    #1;
    check_eq("rst_stall_mret", 32'(stall), 32'd1);
    mret = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios.
    m_mtvec = 32'h100;
    run_seq(1, 4'd2, 32'd24, 32'h0050_207F, 0, "illegal");
    run_seq(0, 4'd0, 32'd0, 32'd0, 0, "mret");
    m_mtvec = 32'h103;
    run_seq(1, 4'd5, 32'd32, 32'd76, 0, "ramfault");
    m_mtvec = 32'h200;
    run_seq(1, 4'd1, 32'd112, 32'd0, 1, "both");

    // Reset abort during SAVE_CAUSE.
    snap_cause = cnt_mcause;
    snap_tval  = cnt_mtval;
    @(negedge clk);
    exc_valid = 1'b1;
    exc_cause = 4'd2;
    exc_pc    = 32'h40;
    exc_tval  = 32'h1234;
    @(posedge clk);
    #1;
    exc_valid = 1'b0;
    @(posedge clk);
    #2;
    check_eq("abort_in_cause", 32'(csr), 32'h342);
    rst_n = 1'b0;
    #1;
    check_eq("abort_csr_w", 32'(csr_w), 32'd0);
    check_eq("abort_csr", 32'(csr), 32'd0);
    check_eq("abort_wd", wd, 32'd0);
    check_eq("abort_target", pc_target, 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_stall", 32'(stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_no_mcause", 32'(cnt_mcause), 32'(snap_cause));
    check_eq("abort_no_mtval", 32'(cnt_mtval), 32'(snap_tval));
    check_eq("abort_idle", 32'(busy), 32'd0);
    exp_mepc = 32'h40;  // mepc was written before the abort
    m_mtvec = 32'h300;
    run_seq(1, 4'd2, 32'd24, 32'h0050_207F, 0, "post_abort");

    // Random traffic.
    for (int i = 0; i < 12; i++) begin
      m_mtvec = $urandom;
      r_cause = 4'($urandom_range(0, 15));
      r_pc    = $urandom;
      r_tval  = $urandom;
      if ($urandom_range(0, 2) == 2) run_seq(0, 4'd0, 32'd0, 32'd0, 0, $sformatf("rnd%0d_mret", i));
      else run_seq(1, r_cause, r_pc, r_tval, $urandom_range(0, 1) == 1, $sformatf("rnd%0d_exc", i));
    end

    check_eq("mtval_write_count", 32'(cnt_mtval), 32'(exp_mtval_cnt));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
